// File: rtl/tt_host_bridge.sv
// tt_host_bridge: UART 8N1 host bridge that drives and reads back the TinyTapeout wrapper pins
module tt_host_bridge #(
   parameter int CLK_DIV    = 16,
   parameter int RST_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic       tx_o,
   output logic [7:0] ui_in,
   output logic [7:0] uio_in,
   output logic       ena,
   output logic       rst_n,
   input  logic [7:0] uo_out,
   input  logic [7:0] uio_out,
   input  logic [7:0] uio_oe
);
   localparam logic [11:0] HALF = 12'(CLK_DIV / 2 - 1);
   localparam logic [11:0] FULL = 12'(CLK_DIV - 1);
   localparam logic [7:0]  RSTC = 8'(RST_CYCLES);
   typedef enum logic [1:0] {CMD, DATA, RSTP} state_t;
   logic        r_rx_busy, r_rx_prev, r_rx_valid, r_rx_err;
   logic [11:0] r_rx_cnt;
   logic [3:0]  r_rx_bit;
   logic [7:0]  r_rx_sh, r_rx_data;
   state_t      r_st;
   logic [1:0]  r_sel;
   logic [7:0]  r_ui, r_uio, r_rcnt;
   logic        r_ena, r_rst_n;
   logic        r_tx_busy;
   logic [9:0]  r_tx_sh;
   logic [11:0] r_tx_cnt;
   logic [3:0]  r_tx_bits;
   logic [7:0]  r_h0, r_h1;
   logic [1:0]  r_hn;
   logic        w_tx_idle, w_is_wr, w_push, w_push2, w_load;
   logic [7:0]  w_b0;
   assign w_tx_idle = !r_tx_busy && r_hn == 2'd0;
   assign w_is_wr   = r_rx_data == 8'h01 || r_rx_data == 8'h02 || r_rx_data == 8'h03 || r_rx_data == 8'h06;
   assign w_push    = r_rx_valid && r_st == CMD && !w_is_wr && w_tx_idle;
   assign w_push2   = r_rx_data == 8'h05;
   assign w_b0      = r_rx_data == 8'h04 ? uo_out : w_push2 ? uio_out : 8'hEE;
   assign w_load    = r_hn != 2'd0 && (!r_tx_busy || (r_tx_cnt == 12'd0 && r_tx_bits == 4'd0));
   assign tx_o      = r_tx_sh[0];
   assign ui_in     = r_ui;
   assign uio_in    = r_uio;
   assign ena       = r_ena;
   assign rst_n     = r_rst_n;
   // RX: detect start edge, sample mid-bit, flag a good byte or a framing error for one clock
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_busy  <= 1'b0;
         r_rx_prev  <= 1'b1;
         r_rx_valid <= 1'b0;
         r_rx_err   <= 1'b0;
         r_rx_cnt   <= 12'd0;
         r_rx_bit   <= 4'd0;
         r_rx_sh    <= 8'h00;
         r_rx_data  <= 8'h00;
      end else begin
         r_rx_prev  <= rx_i;
         r_rx_valid <= 1'b0;
         r_rx_err   <= 1'b0;
         if (!r_rx_busy) begin
            r_rx_busy <= r_rx_prev && !rx_i;
            r_rx_cnt  <= HALF;
            r_rx_bit  <= 4'd0;
         end else if (r_rx_cnt != 12'd0) begin
            r_rx_cnt <= r_rx_cnt - 12'd1;
         end else begin
            r_rx_cnt <= FULL;
            r_rx_bit <= r_rx_bit + 4'd1;
            if (r_rx_bit == 4'd9) begin
               r_rx_busy  <= 1'b0;
               r_rx_valid <= rx_i;
               r_rx_err   <= !rx_i;
               r_rx_data  <= r_rx_sh;
            end else if (r_rx_bit == 4'd0) begin
               r_rx_busy <= !rx_i;
            end else begin
               r_rx_sh <= {rx_i, r_rx_sh[7:1]};
            end
         end
      end
   end
   // Parser: decode commands, update wrapper inputs and time every rst_n low pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_st    <= CMD;
         r_sel   <= 2'd0;
         r_ui    <= 8'h00;
         r_uio   <= 8'h00;
         r_ena   <= 1'b0;
         r_rst_n <= 1'b0;
         r_rcnt  <= RSTC;
      end else begin
         if (r_rcnt != 8'd0) begin
            r_rcnt  <= r_rcnt - 8'd1;
            r_rst_n <= r_rcnt == 8'd1;
         end
         if (r_st == RSTP && r_rcnt <= 8'd1) r_st <= CMD;
         if (r_rx_err && r_st == DATA) r_st <= CMD;
         if (r_rx_valid && r_st == CMD) begin
            if (r_rx_data == 8'h01 || r_rx_data == 8'h02 || r_rx_data == 8'h06) begin
               r_st  <= DATA;
               r_sel <= r_rx_data == 8'h01 ? 2'd0 : r_rx_data == 8'h02 ? 2'd1 : 2'd2;
            end else if (r_rx_data == 8'h03) begin
               r_st    <= RSTP;
               r_rcnt  <= RSTC;
               r_rst_n <= 1'b0;
            end
         end else if (r_rx_valid && r_st == DATA) begin
            r_ui  <= r_sel == 2'd0 ? r_rx_data : r_ui;
            r_uio <= r_sel == 2'd1 ? r_rx_data : r_uio;
            r_ena <= r_sel == 2'd2 ? r_rx_data[0] : r_ena;
            r_st  <= CMD;
         end
      end
   end
   // TX: two-entry holding buffer feeding a 10-bit frame shifter, next frame chained on the stop-bit end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_busy <= 1'b0;
         r_tx_sh   <= '1;
         r_tx_cnt  <= 12'd0;
         r_tx_bits <= 4'd0;
         r_h0      <= 8'h00;
         r_h1      <= 8'h00;
         r_hn      <= 2'd0;
      end else if (w_push) begin
         r_h0 <= w_b0;
         r_h1 <= uio_oe;
         r_hn <= w_push2 ? 2'd2 : 2'd1;
      end else if (w_load) begin
         r_tx_sh   <= {1'b1, r_h0, 1'b0};
         r_tx_busy <= 1'b1;
         r_tx_cnt  <= FULL;
         r_tx_bits <= 4'd9;
         r_h0      <= r_h1;
         r_hn      <= r_hn - 2'd1;
      end else if (r_tx_busy) begin
         if (r_tx_cnt != 12'd0) begin
            r_tx_cnt <= r_tx_cnt - 12'd1;
         end else if (r_tx_bits == 4'd0) begin
            r_tx_busy <= 1'b0;
            r_tx_sh   <= '1;
         end else begin
            r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
            r_tx_bits <= r_tx_bits - 4'd1;
            r_tx_cnt  <= FULL;
         end
      end
   end
endmodule

// File: tb/tb_tt_host_bridge.sv
// tb_tt_host_bridge: directed and randomized command traffic against a transaction-level model
module tb_tt_host_bridge;
   localparam int D = 16;
   localparam int H = D / 2;
   localparam int R = 8;
   localparam int LAT = H + 9 * D + 1;
   logic       clk = 1'b0, rst = 1'b1, rx_i = 1'b1;
   logic [7:0] uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'h00;
   logic       tx_o, ena, rst_n;
   logic [7:0] ui_in, uio_in;
   int         checks = 0, errors = 0, cyc = 0, t_start = 0;
   int         ui_chg = -1, uio_chg = -1, ena_chg = -1, rn_fall = -1, rn_rise = -1;
   logic [7:0] rxq[$], expq[$];
   int         rxs[$];
   logic [7:0] m_ui = 8'h00, m_uio = 8'h00;
   logic       m_ena = 1'b0;

   tt_host_bridge #(.CLK_DIV(D), .RST_CYCLES(R)) dut (
      .clk(clk), .rst(rst), .rx_i(rx_i), .tx_o(tx_o), .ui_in(ui_in), .uio_in(uio_in),
      .ena(ena), .rst_n(rst_n), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc <= cyc + 1;
   end

   initial begin : mon
      logic [7:0] pu, puo;
      logic pe, pr;
      pu = 8'h00; puo = 8'h00; pe = 1'b0; pr = 1'b0;
      forever begin
         @(negedge clk);
         if (ui_in !== pu) ui_chg = cyc;
         if (uio_in !== puo) uio_chg = cyc;
         if (ena !== pe) ena_chg = cyc;
         if (pr === 1'b1 && rst_n === 1'b0) rn_fall = cyc;
         if (pr === 1'b0 && rst_n === 1'b1) rn_rise = cyc;
         pu = ui_in; puo = uio_in; pe = ena; pr = rst_n;
      end
   end

   initial begin : dec
      logic [7:0] b;
      int st;
      b = 8'h00;
      forever begin
         @(negedge clk);
         if (tx_o === 1'b0) begin
            st = cyc;
            repeat (H) @(negedge clk);
            if (tx_o === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (D) @(negedge clk);
                  b[i] = tx_o;
               end
               repeat (D) @(negedge clk);
               rxq.push_back(b);
               rxs.push_back(st);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(posedge clk); #1;
      rx_i = 1'b0;
      t_start = cyc + 1;
      repeat (D) @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (D) @(posedge clk); #1;
      end
      rx_i = stop;
      repeat (D) @(posedge clk); #1;
      rx_i = 1'b1;
   endtask

   task automatic txn(input logic [7:0] c, input logic [7:0] d);
      send_byte(c, 1'b1);
      if (c == 8'h01 || c == 8'h02 || c == 8'h06) send_byte(d, 1'b1);
      if (c == 8'h01) m_ui = d;
      else if (c == 8'h02) m_uio = d;
      else if (c == 8'h06) m_ena = d[0];
      else if (c == 8'h04) expq.push_back(uo_out);
      else if (c == 8'h05) begin
         expq.push_back(uio_out);
         expq.push_back(uio_oe);
      end else if (c != 8'h03) expq.push_back(8'hEE);
   endtask

   task automatic chk_resp(input string tag, input int st0);
      repeat (24 * D) @(posedge clk); #1;
      chk({tag, " count"}, 32'(rxq.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size() && i < rxq.size(); i++) chk({tag, " byte"}, 32'(rxq[i]), 32'(expq[i]));
      if (st0 >= 0 && rxs.size() > 0) chk({tag, " start"}, rxs[0], st0);
      if (expq.size() == 2 && rxs.size() == 2) chk({tag, " gap"}, rxs[1] - rxs[0], 10 * D);
      rxq.delete(); rxs.delete(); expq.delete();
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, " ui_in"}, 32'(ui_in), 32'(m_ui));
      chk({tag, " uio_in"}, 32'(uio_in), 32'(m_uio));
      chk({tag, " ena"}, 32'(ena), 32'(m_ena));
   endtask

   task automatic chk_rst_seq(input string tag);
      int low;
      logic txhi;
      low = 0; txhi = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rst_n === 1'b0) low++;
         if (tx_o !== 1'b1) txhi = 1'b0;
      end
      chk({tag, " low clocks"}, low, R);
      chk({tag, " rst_n high"}, 32'(rst_n), 32'd1);
      chk({tag, " tx idle"}, 32'(txhi), 32'd1);
   endtask

   initial begin
      logic [7:0] c, d;
      int k, target;
      rst = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("reset ui_in", 32'(ui_in), 32'h00);
      chk("reset uio_in", 32'(uio_in), 32'h00);
      chk("reset ena", 32'(ena), 32'd0);
      chk("reset rst_n", 32'(rst_n), 32'd0);
      chk("reset tx_o", 32'(tx_o), 32'd1);
      rst = 1'b0;
      chk_rst_seq("powerup");

      txn(8'h01, 8'hA5);
      chk("wr ui_in", 32'(ui_in), 32'hA5);
      chk("wr ui_in latency", ui_chg, t_start + LAT);
      txn(8'h02, 8'h3C);
      chk("wr uio_in", 32'(uio_in), 32'h3C);
      chk("wr uio_in latency", uio_chg, t_start + LAT);
      txn(8'h06, 8'h01);
      chk("wr ena", 32'(ena), 32'd1);
      chk("wr ena latency", ena_chg, t_start + LAT);
      chk_resp("writes", -1);

      uo_out = 8'h5A;
      txn(8'h04, 8'h00);
      chk_resp("rd04", t_start + LAT + 1);
      uio_out = 8'h81; uio_oe = 8'h0F;
      txn(8'h05, 8'h00);
      chk_resp("rd05", t_start + LAT + 1);

      txn(8'h03, 8'h00);
      repeat (20) @(posedge clk); #1;
      chk("rstcmd fall", rn_fall, t_start + LAT);
      chk("rstcmd width", rn_rise - rn_fall, R);
      chk("rstcmd rst_n", 32'(rst_n), 32'd1);
      chk_resp("rstcmd", -1);

      txn(8'h7F, 8'h00);
      chk_resp("unknown", t_start + LAT + 1);
      chk_regs("unknown");

      send_byte(8'h01, 1'b0);
      txn(8'h01, 8'h11);
      chk_resp("framing", -1);
      chk_regs("framing");

      @(posedge clk); #1;
      rx_i = 1'b0;
      repeat (3) @(posedge clk); #1;
      rx_i = 1'b1;
      chk_resp("glitch", -1);
      chk_regs("glitch");

      uio_out = 8'h33; uio_oe = 8'hC4; uo_out = 8'h99;
      txn(8'h05, 8'h00);
      send_byte(8'h04, 1'b1);
      chk_resp("busy drop", -1);

      for (int n = 0; n < 24; n++) begin
         k = int'($urandom_range(0, 5));
         d = 8'($urandom);
         uo_out = 8'($urandom); uio_out = 8'($urandom); uio_oe = 8'($urandom);
         c = k == 0 ? 8'h01 : k == 1 ? 8'h02 : k == 2 ? 8'h06 : k == 3 ? 8'h04 : k == 4 ? 8'h05 : 8'($urandom_range(7, 255));
         txn(c, d);
         chk_resp("random", -1);
         chk_regs("random");
      end

      uo_out = 8'h00;
      send_byte(8'h04, 1'b1);
      target = t_start + LAT + 1 + 5 * D + 4;
      for (int i = 0; i < 400 && cyc < target; i++) @(posedge clk);
      #1;
      chk("midrst tx bit4", 32'(tx_o), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst tx_o", 32'(tx_o), 32'd1);
      chk("midrst ui_in", 32'(ui_in), 32'h00);
      chk("midrst ena", 32'(ena), 32'd0);
      chk("midrst rst_n", 32'(rst_n), 32'd0);
      rst = 1'b0;
      m_ui = 8'h00; m_uio = 8'h00; m_ena = 1'b0;
      chk_rst_seq("midrst");
      repeat (12 * D) @(posedge clk); #1;
      rxq.delete(); rxs.delete();
      txn(8'h01, 8'h42);
      chk_resp("post reset", -1);
      chk_regs("post reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tt_host_bridge.md
# tt_host_bridge

Serial host-control stage that sits directly upstream of the TinyTapeout project wrapper in a fabric user design. It drives the wrapper's `UI_IN`, `UIO_IN`, `ENA` and `RST_N` inputs from commands received over a UART-style 8N1 line. It consumes `UO_OUT`, `UIO_OUT` and `UIO_OE` and returns them to the host on request. This replaces the constant ties (`ENA`=1, `RST_N`=0) with host-controllable, sequenced values.

## Interface
Parameters:
- `CLK_DIV`, default 16: clocks per UART bit; legal range 4..4095.
- `RST_CYCLES`, default 8: length in clocks of every `rst_n` low pulse; legal range 1..255.

Ports:
- `clk`  input  1  sole clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rx_i`  input  1  host serial in; idle high; 8N1, LSB first. Already synchronised to `clk`.
- `tx_o`  output  1  host serial out; idle high; 8N1, LSB first.
- `ui_in`  output  8  to wrapper `UI_IN`.
- `uio_in`  output  8  to wrapper `UIO_IN`.
- `ena`  output  1  to wrapper `ENA`.
- `rst_n`  output  1  to wrapper `RST_N`; active low.
- `uo_out`  input  8  from wrapper `UO_OUT`.
- `uio_out`  input  8  from wrapper `UIO_OUT`.
- `uio_oe`  input  8  from wrapper `UIO_OE`.

## Operation
- **Reset values** (while `rst`=1):
  - `ui_in`=0x00, `uio_in`=0x00, `ena`=0, `rst_n`=0, `tx_o`=1.
  - RX, parser and TX return to IDLE.
  - Any byte in flight is discarded.
- **Power-up reset pulse:** after `rst` falls, `rst_n` stays 0 for exactly `RST_CYCLES` further clocks, then goes to 1.
- **RX framing:**
  - A falling edge on `rx_i` in RX IDLE starts a frame.
  - `rx_i` is sampled at offset `CLK_DIV/2` (start bit), then every `CLK_DIV` clocks for 8 data bits and 1 stop bit.
  - If `rx_i` is 1 at the start-bit sample, the frame is a glitch: return to IDLE, no byte is produced.
  - If the stop bit is 0, it is a framing error: the byte is dropped and the parser returns to CMD.
  - A good byte produces a one-clock internal `rx_valid`.
- **Parser states:** CMD, DATA, RSTP.
  - In CMD, the received byte is decoded:
    - 0x01: write `ui_in`; go to DATA.
    - 0x02: write `uio_in`; go to DATA.
    - 0x06: write `ena` from data bit 0; go to DATA.
    - 0x03: go to RSTP. Drive `rst_n`=0 for `RST_CYCLES` clocks, then `rst_n`=1 and return to CMD. Bytes received during RSTP are dropped.
    - 0x04: snapshot `uo_out` and send 1 byte.
    - 0x05: snapshot `uio_out` and `uio_oe` in the same clock; send `uio_out` then `uio_oe`.
    - Any other byte: send 0xEE.
  - In DATA, the next good byte is written to the selected register and the parser returns to CMD.
- **TX:**
  - 2-entry holding buffer; frames are 1 start bit, 8 data bits and 1 stop bit, each `CLK_DIV` clocks.
  - A 2-byte response is sent back-to-back: the second start bit follows the first stop bit with no idle gap.
  - A response-generating command decoded while TX is non-IDLE is dropped silently. Write commands always execute regardless of TX state.
- **`rst` mid-operation:** all state aborts and `tx_o` is forced to 1 on the same edge. The power-up `rst_n` sequence then re-runs.

## Timing
- Byte valid is defined as the stop-bit sample, at frame start edge + 9·`CLK_DIV` + `CLK_DIV/2` clocks.
- Register write latency: `ui_in`, `uio_in` and `ena` change on the clock edge after the data byte's `rx_valid` (1 clock).
- Reset command latency: `rst_n` falls 1 clock after the 0x03 byte's `rx_valid`. It is low for exactly `RST_CYCLES` clocks.
- Read latency:
  - The snapshot is taken on the `rx_valid` clock.
  - `tx_o` start bit begins on the following clock.
  - The response lasts 10·`CLK_DIV` clocks per byte.
- A new RX start edge may arrive on the clock after the stop-bit sample; no byte is lost.

## Test plan
- **Reset sequence:** `rst` high 3 clocks, then low. Required: all outputs hold their reset values; `rst_n`=0 for 8 clocks after `rst` falls, then 1; `tx_o`=1 throughout.
- **Write path** (`CLK_DIV`=16): send 0x01,0xA5 then 0x02,0x3C then 0x06,0x01. Required: `ui_in`=0xA5, `uio_in`=0x3C, `ena`=1, each 1 clock after its data byte's `rx_valid`.
- **Reads:**
  - With `uo_out`=0x5A, send 0x04. Required: `tx_o` frame carries 0x5A.
  - With `uio_out`=0x81 and `uio_oe`=0x0F, send 0x05. Required: frames 0x81 then 0x0F, back-to-back.
- **Reset pulse and unknown command:**
  - Send 0x03. Required: `rst_n` low exactly 8 clocks.
  - Send 0x7F. Required: response 0xEE; no register changes.
- **Errors:**
  - Send 0x01 with stop bit forced 0. Required: no change; the next 0x01,0x11 sets `ui_in`=0x11.
  - Send a 0x04 while a 0x05 response is transmitting. Required: only 2 bytes are sent.
- **Mid-frame reset:** assert `rst` during TX bit 4. Required: `tx_o`=1 on the next edge; `ui_in`=0x00; `rst_n` sequence re-runs.
